// File: rtl/pc_redirect_unit.sv
// Fetch PC sequencer: next-PC select, JR/J/branch redirect, IF/ID flush, link registration. Optional: DELAY_SLOT_EN.
// Latency: redirect lands on oPC one edge after acceptance; flush/addr-err pulse in the cycle after that edge; oPC4 combinational.
// Backpressure: iStall freezes PC and link regs; a redirect without iIMemAck parks in HOLD until the fetch completes.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iStall,
    input  logic        iBranch,
    input  logic        iLink,
    input  logic        iJump,
    input  logic        iJal,
    input  logic        iJumpReg,
    input  logic [31:0] iIDPC4,
    input  logic [31:0] iImm,
    input  logic [25:0] iJAddr,
    input  logic [31:0] iRegA,
    input  logic        iIMemAck,
    output logic        oIMemReq,
    output logic [31:0] oPC,
    output logic [31:0] oPC4,
    output logic        oFlushIFID,
    output logic [31:0] oLinkAddr,
    output logic        oLinkWrite,
    output logic        oAddrErr,
    output logic        oRedirectPending
);

    typedef enum logic {RUN, HOLD} state_t;

`ifdef DELAY_SLOT_EN
    localparam logic FLUSH_IN_RUN = 1'b0;
    localparam logic [31:0] LINK_OFS = 32'd4;
`else
    localparam logic FLUSH_IN_RUN = 1'b1;
    localparam logic [31:0] LINK_OFS = 32'd0;
`endif

    state_t      state;
    logic [31:0] pend_q;
    logic [31:0] target;
    logic        redir;
    logic        fetch_ack;
    logic        jr_misaligned;

    // IF/ID substitutes NOP_INSTR itself when oFlushIFID is high; iImm[31:30] fall off the word shift.
    logic unused_ok;
    assign unused_ok = ^{iImm[31:30], NOP_INSTR};

    assign redir         = !iStall && (iJumpReg || iJump || iBranch);
    assign fetch_ack     = iIMemAck && oIMemReq;
    assign jr_misaligned = iJumpReg && (iRegA[1:0] != 2'b00);
    assign oPC4          = oPC + 32'd4;
    assign oRedirectPending = (state == HOLD);

    always_comb begin
        target = iIDPC4 + {iImm[29:0], 2'b00};
        if (iJumpReg) begin
            target = {iRegA[31:2], 2'b00};
        end else if (iJump) begin
            target = {iIDPC4[31:28], iJAddr, 2'b00};
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state      <= RUN;
            oPC        <= RESET_PC;
            pend_q     <= RESET_PC;
            oIMemReq   <= 1'b0;
            oFlushIFID <= 1'b0;
            oLinkAddr  <= 32'd0;
            oLinkWrite <= 1'b0;
            oAddrErr   <= 1'b0;
        end else begin
            oIMemReq   <= 1'b1;
            oFlushIFID <= 1'b0;
            oAddrErr   <= 1'b0;

            if (!iStall) begin
                oLinkWrite <= iLink || (iJal && (iJump || iJumpReg));
                oLinkAddr  <= iIDPC4 + LINK_OFS;
            end

            case (state)
                RUN: begin
                    if (redir) begin
                        oAddrErr <= jr_misaligned;
                        if (fetch_ack) begin
                            oPC        <= target;
                            oFlushIFID <= FLUSH_IN_RUN;
                        end else begin
                            pend_q <= target;
                            state  <= HOLD;
                        end
                    end else if (!iStall && fetch_ack) begin
                        oPC <= oPC + 32'd4;
                    end
                end
                HOLD: begin
                    // The word returned here was fetched down the wrong path.
                    if (fetch_ack) begin
                        oPC        <= pend_q;
                        oFlushIFID <= 1'b1;
                        state      <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_pc_redirect_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
`ifdef DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic        iCLK = 1'b0;
    logic        iRST_n;
    logic        iStall, iBranch, iLink, iJump, iJal, iJumpReg, iIMemAck;
    logic [31:0] iIDPC4, iImm, iRegA;
    logic [25:0] iJAddr;
    logic        oIMemReq, oFlushIFID, oLinkWrite, oAddrErr, oRedirectPending;
    logic [31:0] oPC, oPC4, oLinkAddr;

    always #5 iCLK = ~iCLK;

    pc_redirect_unit dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .iStall(iStall), .iBranch(iBranch),
        .iLink(iLink), .iJump(iJump), .iJal(iJal), .iJumpReg(iJumpReg),
        .iIDPC4(iIDPC4), .iImm(iImm), .iJAddr(iJAddr), .iRegA(iRegA),
        .iIMemAck(iIMemAck), .oIMemReq(oIMemReq), .oPC(oPC), .oPC4(oPC4),
        .oFlushIFID(oFlushIFID), .oLinkAddr(oLinkAddr), .oLinkWrite(oLinkWrite),
        .oAddrErr(oAddrErr), .oRedirectPending(oRedirectPending)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [31:0] m_pc, m_pend, m_la;
    bit          m_hold, m_req, m_flush, m_lw, m_err;

    task automatic model_reset();
        m_pc = RST_PC; m_pend = 32'd0; m_la = 32'd0;
        m_hold = 0; m_req = 0; m_flush = 0; m_lw = 0; m_err = 0;
    endtask

    task automatic model_step();
        bit          ack, redir;
        logic [31:0] tgt;
        ack   = iIMemAck && m_req;
        redir = !iStall && (iJumpReg || iJump || iBranch);
        if (iJumpReg)   tgt = iRegA & 32'hFFFF_FFFC;
        else if (iJump) tgt = {iIDPC4[31:28], iJAddr, 2'b00};
        else            tgt = iIDPC4 + iImm * 4;
        m_flush = 0;
        m_err   = 0;
        if (!iStall) begin
            m_lw = iLink || (iJal && (iJump || iJumpReg));
            m_la = DS ? iIDPC4 + 4 : iIDPC4;
        end
        if (m_hold) begin
            if (ack) begin m_pc = m_pend; m_hold = 0; m_flush = 1; end
        end else if (redir) begin
            m_err = iJumpReg && (iRegA % 4 != 0);
            if (ack) begin m_pc = tgt; m_flush = !DS; end
            else     begin m_pend = tgt; m_hold = 1; end
        end else if (!iStall && ack) begin
            m_pc = m_pc + 4;
        end
        m_req = 1;
    endtask

    task automatic check_all();
        chk("pc", oPC, m_pc);
        chk("pc4", oPC4, m_pc + 4);
        chk("req", oIMemReq, m_req);
        chk("flush", oFlushIFID, m_flush);
        chk("link_addr", oLinkAddr, m_la);
        chk("link_wr", oLinkWrite, m_lw);
        chk("addr_err", oAddrErr, m_err);
        chk("pending", oRedirectPending, m_hold);
    endtask

    task automatic cycle();
        @(posedge iCLK);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        iStall = 0; iBranch = 0; iLink = 0; iJump = 0; iJal = 0; iJumpReg = 0;
        iIDPC4 = 32'd0; iImm = 32'd0; iJAddr = 26'd0; iRegA = 32'd0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pc"}, oPC, RST_PC);
        chk({tag, "_req"}, oIMemReq, 1'b0);
        chk({tag, "_flush"}, oFlushIFID, 1'b0);
        chk({tag, "_la"}, oLinkAddr, 32'd0);
        chk({tag, "_lw"}, oLinkWrite, 1'b0);
        chk({tag, "_err"}, oAddrErr, 1'b0);
        chk({tag, "_pend"}, oRedirectPending, 1'b0);
    endtask

    logic [31:0] pc_before;

    initial begin
        idle_inputs();
        iIMemAck = 1;
        iRST_n   = 0;
        #12;
        check_reset_values("rst");
        model_reset();
        @(posedge iCLK); #1;
        iRST_n = 1;

        // Sequential fetch after release
        cycle(); chk("seq0", oPC, 32'h0040_0000);
        cycle(); chk("seq1", oPC, 32'h0040_0004);
        cycle(); chk("seq2", oPC, 32'h0040_0008); chk("seq2_flush", oFlushIFID, 1'b0);

        // Backward branch
        iBranch = 1; iIDPC4 = 32'h0040_0010; iImm = 32'hFFFF_FFFC;
        cycle(); chk("br_pc", oPC, 32'h0040_0000); chk("br_flush", oFlushIFID, DS ? 1'b0 : 1'b1);
        idle_inputs();

        // JR wins over J and branch, misaligned target
        iJumpReg = 1; iJump = 1; iBranch = 1; iRegA = 32'h0040_0103;
        iIDPC4 = 32'h0040_0050; iJAddr = 26'h3FF_FFFF; iImm = 32'd8;
        cycle(); chk("jr_pc", oPC, 32'h0040_0100); chk("jr_err", oAddrErr, 1'b1);
        idle_inputs();
        cycle(); chk("jr_err_clear", oAddrErr, 1'b0);

        // Jump without ack parks in HOLD, then resolves
        iIMemAck = 0; iJump = 1; iJAddr = 26'h010_0040; iIDPC4 = 32'h0040_0020;
        pc_before = oPC;
        cycle(); chk("hold_pend", oRedirectPending, 1'b1); chk("hold_pc", oPC, pc_before);
        idle_inputs();
        iBranch = 1; iImm = 32'd100;
        for (int i = 0; i < 3; i++) begin
            cycle(); chk("hold_wait", oRedirectPending, 1'b1);
        end
        iBranch = 0;
        iIMemAck = 1;
        cycle();
        chk("hold_pc_done", oPC, 32'h0040_0100);
        chk("hold_flush", oFlushIFID, 1'b1);
        chk("hold_exit", oRedirectPending, 1'b0);

        // Link without taken branch, then stall freezes everything
        iLink = 1; iIDPC4 = 32'h0040_0030;
        cycle();
        chk("link_wr", oLinkWrite, 1'b1);
        chk("link_addr", oLinkAddr, DS ? 32'h0040_0034 : 32'h0040_0030);
        pc_before = oPC;
        iLink = 0; iStall = 1; iBranch = 1; iIDPC4 = 32'h0040_0080; iImm = 32'd4;
        cycle();
        chk("stall_pc", oPC, pc_before);
        chk("stall_lw", oLinkWrite, 1'b1);
        chk("stall_la", oLinkAddr, DS ? 32'h0040_0034 : 32'h0040_0030);
        idle_inputs();

        // Reset in the middle of HOLD
        iIMemAck = 0; iJump = 1; iJAddr = 26'h000_1234;
        cycle(); chk("mid_hold", oRedirectPending, 1'b1);
        idle_inputs();
        #2 iRST_n = 0;
        #1 check_reset_values("mid_rst");
        model_reset();
        iIMemAck = 1;
        @(negedge iCLK);
        iRST_n = 1;
        cycle(); chk("post_rst0", oPC, 32'h0040_0000);
        cycle(); chk("post_rst1", oPC, 32'h0040_0004);

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            iStall   = ($urandom_range(0, 7) == 0);
            iBranch  = ($urandom_range(0, 5) == 0);
            iJump    = ($urandom_range(0, 7) == 0);
            iJumpReg = ($urandom_range(0, 9) == 0);
            iJal     = $urandom_range(0, 1);
            iLink    = ($urandom_range(0, 5) == 0);
            iIMemAck = ($urandom_range(0, 9) < 7);
            iIDPC4   = $urandom;
            iImm     = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed($urandom_range(0, 64)) - 32);
            iJAddr   = 26'($urandom);
            iRegA    = $urandom;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Fetch-stage PC sequencer sitting directly downstream of the ID-stage branch decision logic in the pipelined MIPS core.
- Consumes the taken/link decisions, jump and jump-register requests, and computes the next PC.
- Handshakes with instruction memory, flushes IF/ID on redirect, and registers the link address/write-enable into ID/EX.

Parameters:
RESET_PC  32'h0040_0000  PC value loaded on reset
NOP_INSTR  32'h0000_0000  instruction injected into IF/ID on flush

Ports:
iCLK  input  1  core clock, rising edge
iRST_n  input  1  asynchronous, active-low reset
iStall  input  1  hazard stall: hold PC and IF/ID, ignore redirect inputs this cycle
iBranch  input  1  branch taken (from branch decision stage)
iLink  input  1  branch-and-link request (from branch decision stage)
iJump  input  1  J/JAL in ID
iJal  input  1  JAL in ID (valid only with iJump)
iJumpReg  input  1  JR/JALR in ID
iIDPC4  input  32  address of ID instruction + 4
iImm  input  32  sign-extended branch offset (words)
iJAddr  input  26  jump index field
iRegA  input  32  forwarded rs value for JR
iIMemAck  input  1  instruction word valid for oPC this cycle
oIMemReq  output  1  fetch request for oPC
oPC  output  32  current fetch address
oPC4  output  32  oPC + 4, combinational
oFlushIFID  output  1  replace IF/ID instruction with NOP_INSTR
oLinkAddr  output  32  registered return address to ID/EX
oLinkWrite  output  1  registered write-enable for $ra
oAddrErr  output  1  one-cycle pulse: JR target not word-aligned
oRedirectPending  output  1  high in HOLD state

Behaviour:
- Reset (async, iRST_n=0): oPC=RESET_PC, state=RUN, oFlushIFID=0, oLinkAddr=0, oLinkWrite=0, oAddrErr=0, oIMemReq=0; oIMemReq goes 1 on the first edge after release.
- redir = !iStall & (iJumpReg | iJump | iBranch). Priority: iJumpReg > iJump > iBranch.
- Targets: JR = {iRegA[31:2],2'b00}; J = {iIDPC4[31:28],iJAddr,2'b00}; branch = iIDPC4 + (iImm<<2), modulo 2^32 (wrap silently).
- JR with iRegA[1:0]!=0: the aligned target is still used; oAddrErr pulses on the edge that accepts the redirect.
- State RUN (oIMemReq=1):
  - iIMemAck & redir: oPC<=target; oFlushIFID=1 for that cycle.
  - iIMemAck & !redir & !iStall: oPC<=oPC+4.
  - iStall: oPC held, whatever iIMemAck is. The fetched word is re-fetched later.
  - !iIMemAck & redir: latch target into the pending register; go to HOLD.
- State HOLD (oIMemReq=1, oRedirectPending=1):
  - Redirect inputs are ignored; the ID stage is frozen by the external hazard unit.
  - On iIMemAck: oPC<=pending; oFlushIFID=1 (discard the wrong-path word); go to RUN.
  - No timeout.
- Link registration, on every edge with !iStall:
  - oLinkWrite<=iLink | (iJump&iJal) | (iJumpReg&iJal).
  - oLinkAddr<=link value, defined under Optional Feature.
  - iLink from the branch stage is independent of taken: BGEZAL not-taken still writes $ra.
- With iStall=1, oLinkWrite and oLinkAddr hold their values.
- Latency: redirect visible on oPC one edge after acceptance; oPC4 combinational.

Optional Feature:
- Macro: DELAY_SLOT_EN.
- Defined:
  - MIPS delay-slot semantics; the instruction already in IF is kept.
  - oFlushIFID is driven only in HOLD (wrong-path word) and never in RUN.
  - Link value = iIDPC4+4.
- Undefined:
  - oFlushIFID is asserted as described in Behaviour.
  - Link value = iIDPC4.

Test Plan:
- Reset release, iIMemAck=1 each cycle, no redirects -> oPC sequence 0x00400000, 0x00400004, 0x00400008; oFlushIFID=0.
- RUN with iIMemAck=1, iBranch=1, iIDPC4=0x00400010, iImm=0xFFFFFFFC -> next oPC=0x00400000. oFlushIFID=1 without DELAY_SLOT_EN, 0 with it.
- iJumpReg=1, iJump=1, iBranch=1 together, iRegA=0x00400103 -> oPC=0x00400100, oAddrErr pulses once, J/branch targets ignored.
- iIMemAck=0 with iJump=1, iJAddr=0x0100040, iIDPC4=0x00400020 -> state HOLD. Three wait cycles, then ack -> oPC=0x00400100, oFlushIFID=1, back in RUN.
- iLink=1, iBranch=0, iIDPC4=0x00400030 -> oLinkWrite=1 next edge, oLinkAddr=0x00400034 (DELAY_SLOT_EN) / 0x00400030 (undefined). With iStall=1 and iBranch=1 -> oPC and link outputs unchanged.
- iRST_n asserted mid-HOLD -> immediate oPC=0x00400000, state RUN, pending target discarded, all registered outputs 0.
